rp_acq_ctrl: RTL and testbench

Acquisition sequencer for one scope channel in the ADC clock domain. Arms the channel's trigger-source selector, counts pre-trigger samples, waits for the selected trigger, counts post-trigger delay samples and signals completion. Optionally re-arms in continuous mode. Sits between the register bank (config/commands) and the trigger selector plus buffer write logic, driving their source/new/reset/delay-done/disarm-clear strobes.

---
 rtl/rp_acq_pkg.sv | 31 +++
 rtl/rp_acq_cnt.sv | 33 +++
 rtl/rp_acq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rp_acq_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rp_acq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rp_acq_pkg : state codes and trigger-source codes for the acquisition FSM  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package rp_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ARM  = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } acq_state_t;

  localparam logic [3:0] c_SRC_SW     = 4'd1;
  localparam logic [3:0] c_SRC_CHA_PE = 4'd2;
  localparam logic [3:0] c_SRC_CHA_NE = 4'd3;
  localparam logic [3:0] c_SRC_CHB_PE = 4'd4;
  localparam logic [3:0] c_SRC_CHB_NE = 4'd5;
  localparam logic [3:0] c_SRC_EXT_PE = 4'd6;
  localparam logic [3:0] c_SRC_EXT_NE = 4'd7;
  localparam logic [3:0] c_SRC_ASG_PE = 4'd8;
  localparam logic [3:0] c_SRC_ASG_NE = 4'd9;
  localparam logic [3:0] c_SRC_LA_PE  = 4'd10;
  localparam logic [3:0] c_SRC_LA_NE  = 4'd11;
  localparam logic [3:0] c_SRC_D_PE   = 4'd12;
  localparam logic [3:0] c_SRC_D_NE   = 4'd13;

endpackage
`default_nettype wire

// File: rtl/rp_acq_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rp_acq_cnt : clear/enable saturating counter with equality compare         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rp_acq_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_thr,
  output logic [W-1:0] o_cnt,
  output logic         o_eq
);

  logic [W-1:0] r_cnt;

  // Holds at all-ones instead of wrapping so a stuck count never re-matches.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_eq  = (r_cnt == i_thr);

endmodule
`default_nettype wire

// File: rtl/rp_acq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rp_acq_ctrl : per-channel acquisition sequencer (arm/pre/trigger/post)     |
// | Optional auto-trigger timeout: ACQ_TRIG_TMO_EN          Rev 1.0            |
// +----------------------------------------------------------------------------+
module rp_acq_ctrl
  import rp_acq_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TMO_W = 32
) (
  input  logic             adc_clk_i,
  input  logic             adc_rst_i,
  input  logic [3:0]       cfg_src_i,
  input  logic [CNT_W-1:0] cfg_pre_i,
  input  logic [CNT_W-1:0] cfg_dly_i,
  input  logic             cfg_cont_i,
  input  logic [TMO_W-1:0] cfg_tmo_i,
  input  logic             cmd_arm_i,
  input  logic             cmd_rst_i,
  input  logic             smp_val_i,
  input  logic             trig_i,
  output logic [3:0]       set_trg_src_o,
  output logic             set_trg_new_o,
  output logic             adc_rst_do_o,
  output logic             adc_dly_do_o,
  output logic             trig_dis_clr_o,
  output logic             sw_trig_o,
  output logic             done_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] pre_cnt_o,
  output logic [CNT_W-1:0] pst_cnt_o
);

  acq_state_t       r_state;
  logic [3:0]       r_src;
  logic [CNT_W-1:0] r_pre_thr;
  logic [CNT_W-1:0] r_dly_thr;

  logic w_arm;
  logic w_cnt_clr;
  logic w_pre_en;
  logic w_pst_en;
  logic w_pre_eq;
  logic w_pst_eq;

  // Re-arm from DONE is either an explicit command or continuous mode.
  always_comb begin
    w_arm = 1'b0;
    case (r_state)
      ST_IDLE: w_arm = cmd_arm_i;
      ST_DONE: w_arm = cmd_arm_i | cfg_cont_i;
      default: w_arm = 1'b0;
    endcase
  end

  assign w_cnt_clr = cmd_rst_i | w_arm;
  assign w_pre_en  = (r_state == ST_PRE)  && smp_val_i && !w_pre_eq;
  assign w_pst_en  = (r_state == ST_POST) && smp_val_i && !w_pst_eq;

  rp_acq_cnt #(.W(CNT_W)) u_pre_cnt (
    .clk   (adc_clk_i),
    .rst   (adc_rst_i),
    .i_clr (w_cnt_clr),
    .i_en  (w_pre_en),
    .i_thr (r_pre_thr),
    .o_cnt (pre_cnt_o),
    .o_eq  (w_pre_eq)
  );

  rp_acq_cnt #(.W(CNT_W)) u_pst_cnt (
    .clk   (adc_clk_i),
    .rst   (adc_rst_i),
    .i_clr (w_cnt_clr),
    .i_en  (w_pst_en),
    .i_thr (r_dly_thr),
    .o_cnt (pst_cnt_o),
    .o_eq  (w_pst_eq)
  );

  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_state        <= ST_IDLE;
      r_src          <= '0;
      r_pre_thr      <= '0;
      r_dly_thr      <= '0;
      set_trg_new_o  <= 1'b0;
      adc_rst_do_o   <= 1'b0;
      adc_dly_do_o   <= 1'b0;
      trig_dis_clr_o <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      set_trg_new_o  <= 1'b0;
      adc_rst_do_o   <= 1'b0;
      adc_dly_do_o   <= 1'b0;
      trig_dis_clr_o <= 1'b0;
      if (cmd_rst_i) begin
        adc_rst_do_o <= 1'b1;
        done_o       <= 1'b0;
        r_state      <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_arm) begin
              r_src          <= cfg_src_i;
              r_pre_thr      <= cfg_pre_i;
              r_dly_thr      <= cfg_dly_i;
              trig_dis_clr_o <= 1'b1;
              done_o         <= 1'b0;
              r_state        <= ST_PRE;
            end
          end
          ST_PRE: begin
            if (w_pre_eq) begin
              set_trg_new_o <= 1'b1;
              r_state       <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (trig_i) begin
              r_state <= ST_POST;
            end
          end
          ST_POST: begin
            if (w_pst_eq) begin
              adc_dly_do_o <= 1'b1;
              done_o       <= 1'b1;
              r_state      <= ST_DONE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign set_trg_src_o = r_src;
  assign state_o       = r_state;

`ifdef ACQ_TRIG_TMO_EN
  logic [TMO_W-1:0] r_tmo_thr;
  logic             r_tmo_fired;
  logic             w_tmo_clr;
  logic             w_tmo_en;
  logic             w_tmo_eq;
  logic [TMO_W-1:0] w_tmo_cnt_unused;

  assign w_tmo_clr = (r_state == ST_PRE) && w_pre_eq;
  assign w_tmo_en  = (r_state == ST_ARM) && smp_val_i;

  rp_acq_cnt #(.W(TMO_W)) u_tmo_cnt (
    .clk   (adc_clk_i),
    .rst   (adc_rst_i),
    .i_clr (w_tmo_clr),
    .i_en  (w_tmo_en),
    .i_thr (r_tmo_thr),
    .o_cnt (w_tmo_cnt_unused),
    .o_eq  (w_tmo_eq)
  );

  // One forced trigger per arm; the FSM itself still waits for trig_i.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      r_tmo_thr   <= '0;
      r_tmo_fired <= 1'b0;
      sw_trig_o   <= 1'b0;
    end else begin
      sw_trig_o <= 1'b0;
      if (w_arm && !cmd_rst_i) begin
        r_tmo_thr <= cfg_tmo_i;
      end
      if (w_tmo_clr) begin
        r_tmo_fired <= 1'b0;
      end else if (!cmd_rst_i && (r_state == ST_ARM) && w_tmo_eq &&
                   (r_tmo_thr != '0) && !r_tmo_fired) begin
        sw_trig_o   <= 1'b1;
        r_tmo_fired <= 1'b1;
      end
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^cfg_tmo_i;
  assign sw_trig_o    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rp_acq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rp_acq_ctrl : randomized self-checking bench for rp_acq_ctrl            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_rp_acq_ctrl;

`ifdef ACQ_TRIG_TMO_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_src;
  logic [31:0] cfg_pre, cfg_dly, cfg_tmo;
  logic        cfg_cont, cmd_arm, cmd_rst, smp, trig;
  logic [3:0]  set_trg_src;
  logic        set_trg_new, adc_rst_do, adc_dly_do, trig_dis_clr, sw_trig, done;
  logic [2:0]  state;
  logic [31:0] pre_cnt, pst_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rp_acq_ctrl #(.CNT_W(32), .TMO_W(32)) dut (
    .adc_clk_i      (clk),
    .adc_rst_i      (rst),
    .cfg_src_i      (cfg_src),
    .cfg_pre_i      (cfg_pre),
    .cfg_dly_i      (cfg_dly),
    .cfg_cont_i     (cfg_cont),
    .cfg_tmo_i      (cfg_tmo),
    .cmd_arm_i      (cmd_arm),
    .cmd_rst_i      (cmd_rst),
    .smp_val_i      (smp),
    .trig_i         (trig),
    .set_trg_src_o  (set_trg_src),
    .set_trg_new_o  (set_trg_new),
    .adc_rst_do_o   (adc_rst_do),
    .adc_dly_do_o   (adc_dly_do),
    .trig_dis_clr_o (trig_dis_clr),
    .sw_trig_o      (sw_trig),
    .done_o         (done),
    .state_o        (state),
    .pre_cnt_o      (pre_cnt),
    .pst_cnt_o      (pst_cnt)
  );

  wire [8:0] obs = {state, set_trg_new, adc_rst_do, adc_dly_do, trig_dis_clr, sw_trig, done};

  function automatic logic [8:0] ex(input logic [2:0] st, input bit nw, input bit ra,
                                    input bit dd, input bit cl, input bit sw, input bit dn);
    return {st, nw, ra, dd, cl, sw, dn};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full acquisition: arm (or continuous re-arm), pre count, trigger wait, post count.
  task automatic acq_run(input logic [3:0] src, input int pre, input int dly, input int tmo,
                         input int tw, input bit do_arm, input string tag);
    int k, swk;
    bit fired, hit;
    cfg_src = src; cfg_pre = pre; cfg_dly = dly; cfg_tmo = tmo;
    cmd_arm = do_arm; smp = 1'($urandom); trig = 1'($urandom);
    tick();
    n_vec++;
    if (obs !== ex(1, 0, 0, 0, 1, 0, 0) || set_trg_src !== src || pre_cnt !== 0 || pst_cnt !== 0) begin
      n_err++;
      $display("FAIL %s arm: got obs=%b src=%0d pre=%0d pst=%0d, want obs=%b src=%0d pre=0 pst=0",
               tag, obs, set_trg_src, pre_cnt, pst_cnt, ex(1, 0, 0, 0, 1, 0, 0), src);
    end
    // Configuration is latched at arm; later changes must be ignored.
    cfg_src = 4'($urandom); cfg_pre = $urandom; cfg_dly = $urandom; cfg_tmo = $urandom_range(0, 3);

    k = 0;
    while (k < pre) begin
      smp = 1'($urandom); trig = 1'($urandom); cmd_arm = ($urandom_range(0, 3) == 0);
      tick();
      if (smp) k++;
      n_vec++;
      if (obs !== ex(1, 0, 0, 0, 0, 0, 0) || pre_cnt !== 32'(k)) begin
        n_err++;
        $display("FAIL %s pre: got obs=%b cnt=%0d, want obs=%b cnt=%0d", tag, obs, pre_cnt,
                 ex(1, 0, 0, 0, 0, 0, 0), k);
      end
    end
    smp = 1'($urandom); trig = 1'($urandom); cmd_arm = ($urandom_range(0, 3) == 0);
    tick();
    n_vec++;
    if (obs !== ex(2, 1, 0, 0, 0, 0, 0) || pre_cnt !== 32'(pre) || set_trg_src !== src) begin
      n_err++;
      $display("FAIL %s pre_hit: got obs=%b cnt=%0d src=%0d, want obs=%b cnt=%0d src=%0d", tag, obs,
               pre_cnt, set_trg_src, ex(2, 1, 0, 0, 0, 0, 0), pre, src);
    end

    swk = 0; fired = 0;
    for (int i = 0; i <= tw; i++) begin
      smp = 1'($urandom); trig = (i == tw); cmd_arm = ($urandom_range(0, 3) == 0);
      hit = TMO_ON && (tmo != 0) && !fired && (swk == tmo);
      if (hit) fired = 1;
      if (smp) swk++;
      tick();
      n_vec++;
      if (obs !== ex((i == tw) ? 3'd3 : 3'd2, 0, 0, 0, 0, hit, 0) || pst_cnt !== 0) begin
        n_err++;
        $display("FAIL %s arm_wait[%0d]: got obs=%b pst=%0d, want obs=%b pst=0", tag, i, obs, pst_cnt,
                 ex((i == tw) ? 3'd3 : 3'd2, 0, 0, 0, 0, hit, 0));
      end
    end

    k = 0;
    while (k < dly) begin
      smp = 1'($urandom); trig = 1'($urandom); cmd_arm = ($urandom_range(0, 3) == 0);
      tick();
      if (smp) k++;
      n_vec++;
      if (obs !== ex(3, 0, 0, 0, 0, 0, 0) || pst_cnt !== 32'(k)) begin
        n_err++;
        $display("FAIL %s post: got obs=%b cnt=%0d, want obs=%b cnt=%0d", tag, obs, pst_cnt,
                 ex(3, 0, 0, 0, 0, 0, 0), k);
      end
    end
    smp = 1'($urandom); trig = 1'($urandom); cmd_arm = ($urandom_range(0, 3) == 0);
    tick();
    cmd_arm = 0;
    n_vec++;
    if (obs !== ex(4, 0, 0, 1, 0, 0, 1) || pst_cnt !== 32'(dly)) begin
      n_err++;
      $display("FAIL %s post_hit: got obs=%b cnt=%0d, want obs=%b cnt=%0d", tag, obs, pst_cnt,
               ex(4, 0, 0, 1, 0, 0, 1), dly);
    end
  endtask

  task automatic hold_done(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      smp = 1'($urandom); trig = 1'($urandom); cmd_arm = 0;
      tick();
      n_vec++;
      if (obs !== ex(4, 0, 0, 0, 0, 0, 1)) begin
        n_err++;
        $display("FAIL %s hold: got obs=%b, want obs=%b", tag, obs, ex(4, 0, 0, 0, 0, 0, 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; cmd_arm = 1; smp = 1; trig = 1;
    tick(); tick();
    n_vec++;
    if (obs !== 9'd0 || set_trg_src !== 4'd0 || pre_cnt !== 0 || pst_cnt !== 0) begin
      n_err++;
      $display("FAIL reset: got obs=%b src=%0d pre=%0d pst=%0d, want all 0", obs, set_trg_src, pre_cnt, pst_cnt);
    end
    rst = 0; cmd_arm = 0; smp = 0; trig = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    cfg_src = 7; cfg_pre = 3; cfg_dly = 3; cmd_arm = 1; smp = 1;
    tick(); cmd_arm = 0;
    tick();
    rst = 1; cmd_arm = 1;
    tick();
    n_vec++;
    if (obs !== 9'd0 || set_trg_src !== 4'd0 || pre_cnt !== 0) begin
      n_err++;
      $display("FAIL reset_mid: got obs=%b src=%0d pre=%0d, want all 0", obs, set_trg_src, pre_cnt);
    end
    rst = 0; cmd_arm = 0; smp = 0;
    tick();
  endtask

  task automatic test_abort();
    for (int s = 1; s <= 3; s++) begin
      cfg_src = 9; cfg_pre = 2; cfg_dly = 2; cfg_tmo = 0; cmd_arm = 1; smp = 0; trig = 0;
      tick(); cmd_arm = 0;
      if (s >= 2) begin
        smp = 1; tick(); tick();
        smp = 0; tick();
      end
      if (s == 3) begin
        trig = 1; tick();
        trig = 0; smp = 1; tick();
      end
      n_vec++;
      if (state !== 3'(s)) begin
        n_err++;
        $display("FAIL abort_setup[%0d]: got state=%0d, want %0d", s, state, s);
      end
      cmd_rst = 1; cmd_arm = 1; trig = 1; smp = 1;
      tick();
      n_vec++;
      if (obs !== ex(0, 0, 1, 0, 0, 0, 0) || pre_cnt !== 0 || pst_cnt !== 0) begin
        n_err++;
        $display("FAIL abort[%0d]: got obs=%b pre=%0d pst=%0d, want obs=%b counters 0", s, obs, pre_cnt,
                 pst_cnt, ex(0, 0, 1, 0, 0, 0, 0));
      end
      cmd_rst = 0; cmd_arm = 0; trig = 0; smp = 0;
      tick();
      n_vec++;
      if (obs !== 9'd0) begin
        n_err++;
        $display("FAIL abort_after[%0d]: got obs=%b, want obs=%b", s, obs, 9'd0);
      end
    end
  endtask

  task automatic test_basic();
    acq_run(4'd2, 4, 3, 0, 2, 1'b1, "basic");
    hold_done(3, "basic");
  endtask

  task automatic test_zero_len();
    acq_run(4'd5, 0, 0, 0, 0, 1'b1, "zero");
    hold_done(1, "zero");
  endtask

  task automatic test_continuous();
    cfg_cont = 1;
    acq_run(4'd3, 2, 2, 0, 1, 1'b1, "cont1");
    acq_run(4'd3, 2, 2, 0, 3, 1'b0, "cont2");
    acq_run(4'd11, 1, 0, 0, 0, 1'b0, "cont3");
    cfg_cont = 0;
    hold_done(2, "cont_stop");
  endtask

  task automatic test_timeout();
    acq_run(4'd1, 1, 1, 5, 12, 1'b1, "tmo5");
    acq_run(4'd1, 1, 1, 0, 12, 1'b1, "tmo0");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      acq_run(4'($urandom_range(1, 13)), $urandom_range(0, 6), $urandom_range(0, 6),
              $urandom_range(0, 6), $urandom_range(0, 10), 1'b1, "rand");
      hold_done(1, "rand");
    end
  endtask

  initial begin
    rst = 1; cfg_src = 0; cfg_pre = 0; cfg_dly = 0; cfg_tmo = 0; cfg_cont = 0;
    cmd_arm = 0; cmd_rst = 0; smp = 0; trig = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_continuous();
    test_abort();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
